// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader
//  Description : Upstream feeder for the matrix core. Accepts exactly one job
//                (ROWS*COLS weight words followed by COLS vector words) per
//                start pulse, tags every word with kind/last and buffers it
//                in a small FIFO toward the matrix-core sink port.
//  Ports       : clk      - rising-edge clock
//                rst_n    - synchronous active-low reset
//                start    - job start pulse, honoured only while idle
//                snk_vld  - upstream word valid
//                snk_rdy  - loader can accept a word
//                snk_data - upstream operand word
//                src_vld  - word valid toward matrix core
//                src_rdy  - matrix core accepts word
//                src_data - operand word toward matrix core
//                src_kind - 0 = weight word, 1 = vector word
//                src_last - final word of the job
//                busy     - job in progress (FILL or DRAIN)
//                done     - one-cycle pulse after the last word is handed off
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  snk_vld,
    output logic                  snk_rdy,
    input  logic [DATA_WIDTH-1:0] snk_data,
    output logic                  src_vld,
    input  logic                  src_rdy,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_kind,
    output logic                  src_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_weights = ROWS * COLS;
    localparam int c_total   = c_weights + COLS;
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_occ_w   = c_ptr_w + 1;
    localparam int c_in_w    = $clog2(c_total);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic                  r_mem_kind [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_occ_w-1:0]    r_count;
    logic [c_in_w-1:0]     r_in_cnt;
    logic                  r_done;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tag_kind;
    logic                  w_tag_last;
    logic                  w_last_pop;

    assign w_full  = (r_count == c_occ_w'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on registered state and occupancy; a full FIFO
    // blocks the push even when a pop happens in the same cycle.
    assign snk_rdy = (r_state == ST_FILL) && !w_full;
    assign w_push  = snk_vld && snk_rdy;

    // Output is read straight from the head entry; the head is never
    // overwritten while occupied, so the word holds steady under a stall.
    // Gating with empty keeps the outputs at zero when nothing is pending.
    assign src_vld  = !w_empty;
    assign src_data = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign src_kind = w_empty ? 1'b0 : r_mem_kind[r_rd_ptr];
    assign src_last = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
    assign w_pop    = src_vld && src_rdy;

    assign w_tag_kind = (r_in_cnt >= c_in_w'(c_weights));
    assign w_tag_last = (r_in_cnt == c_in_w'(c_total - 1));
    assign w_last_pop = w_pop && src_last && (r_state == ST_DRAIN);

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FILL;
            ST_FILL:  if (w_push && w_tag_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_in_cnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_pop;

            // The counter is cleared on the final word so it never leaves
            // the range 0..c_total-1.
            if ((r_state == ST_IDLE) && start) begin
                r_in_cnt <= '0;
            end else if (w_push) begin
                r_in_cnt <= w_tag_last ? '0 : r_in_cnt + c_in_w'(1);
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_occ_w'(1);
                2'b01:   r_count <= r_count - c_occ_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= snk_data;
            r_mem_kind[r_wr_ptr] <= w_tag_kind;
            r_mem_last[r_wr_ptr] <= w_tag_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_loader
//  Description : Directed self-checking bench for operand_loader
//                (DATA_WIDTH=8, ROWS=4, COLS=4, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, snk_vld, snk_rdy, src_vld, src_rdy;
    logic       src_kind, src_last, busy, done;
    logic [7:0] snk_data, src_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] q_data [$];
    logic       q_kind [$];
    logic       q_last [$];
    bit         rdy_log  [300];
    bit         busy_log [300];
    int         n_in, first_out, last_cyc, done_cnt, done_cyc, hold_viol;
    bit         hold_pending;
    logic [9:0] hold_word;

    operand_loader #(
        .DATA_WIDTH (8),
        .ROWS       (4),
        .COLS       (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .snk_vld  (snk_vld),
        .snk_rdy  (snk_rdy),
        .snk_data (snk_data),
        .src_vld  (src_vld),
        .src_rdy  (src_rdy),
        .src_data (src_data),
        .src_kind (src_kind),
        .src_last (src_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One cycle: observe just after the inputs settle, then advance to the
    // next falling edge. With chain set, start is raised in the done cycle.
    task automatic tick(input int c, input bit chain);
        #1;
        if (c >= 0 && c < 300) begin
            rdy_log[c]  = snk_rdy;
            busy_log[c] = busy;
        end
        if (hold_pending && (src_vld !== 1'b1 || {src_data, src_kind, src_last} !== hold_word))
            hold_viol++;
        hold_pending = src_vld && !src_rdy;
        hold_word    = {src_data, src_kind, src_last};
        if (src_vld && src_rdy) begin
            q_data.push_back(src_data);
            q_kind.push_back(src_kind);
            q_last.push_back(src_last);
            if (first_out < 0) first_out = c;
            if (src_last) last_cyc = c;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
            if (chain) start = 1'b1;
        end
        if (snk_vld && snk_rdy) n_in++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Streams words base, base+1, ... with snk_vld held high; src_rdy low for
    // the first stall_len cycles; optional stray start at cycle ign_at; stops
    // on done, after abort_at accepted words, or after a 300-cycle budget.
    task automatic run_job(input logic [7:0] base, input bit do_start, input int stall_len,
                           input int ign_at, input bit chain, input int abort_at);
        q_data.delete(); q_kind.delete(); q_last.delete();
        n_in = 0; first_out = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
        hold_viol = 0; hold_pending = 1'b0;
        if (do_start) begin
            start = 1'b1; snk_vld = 1'b0; src_rdy = 1'b1;
            tick(-1, 1'b0);
        end
        for (int c = 0; c < 300; c++) begin
            start    = (c == ign_at);
            snk_vld  = 1'b1;
            snk_data = base + 8'(n_in);
            src_rdy  = (c >= stall_len);
            tick(c, chain);
            if (done_cnt > 0) break;
            if (abort_at > 0 && n_in == abort_at) break;
        end
        start = 1'b0; snk_vld = 1'b0; src_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; snk_vld = 1'b1; snk_data = 8'hEE; src_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            tests++;
            if ({snk_rdy, src_vld, src_data, src_kind, src_last, busy, done} !== 14'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %b expected all zero", k,
                         {snk_rdy, src_vld, src_data, src_kind, src_last, busy, done});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            tests++;
            if ({snk_rdy, src_vld, busy, done} !== 4'b0000) begin
                fails++;
                $display("FAIL idle_no_accept cycle %0d: got rdy/vld/busy/done=%b expected 0000", k,
                         {snk_rdy, src_vld, busy, done});
            end
        end
        snk_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_job();
        logic [9:0] exp_w, got_w;
        run_job(8'h01, 1'b1, 0, -1, 1'b0, 0);
        tests++;
        if (q_data.size() != 20) begin
            fails++; $display("FAIL full_count: got %0d words expected 20", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            exp_w = {8'h01 + 8'(i), (i >= 16), (i == 19)};
            got_w = {q_data[i], q_kind[i], q_last[i]};
            tests++;
            if (got_w !== exp_w) begin
                fails++; $display("FAIL full_word%0d: got %h expected %h", i, got_w, exp_w);
            end
        end
        tests++;
        if (first_out != 1) begin
            fails++; $display("FAIL full_latency: got cycle %0d expected 1", first_out);
        end
        tests++;
        if (last_cyc != 20) begin
            fails++; $display("FAIL full_throughput: last word cycle %0d expected 20", last_cyc);
        end
        tests++;
        if (done_cnt != 1 || done_cyc != 21) begin
            fails++; $display("FAIL full_done: got count %0d cycle %0d expected 1 at 21", done_cnt, done_cyc);
        end
        #1;
        tests++;
        if ({done, busy} !== 2'b00) begin
            fails++; $display("FAIL full_done_once: got done/busy=%b expected 00", {done, busy});
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int acc;
        logic [9:0] exp_w, got_w;
        run_job(8'h21, 1'b1, 10, -1, 1'b0, 0);
        acc = 0;
        for (int c = 0; c < 10; c++) acc += int'(rdy_log[c]);
        tests++;
        if (acc != 4 || rdy_log[9] !== 1'b0) begin
            fails++; $display("FAIL bp_accepted: got %0d words, rdy at end %b expected 4, 0", acc, rdy_log[9]);
        end
        tests++;
        if (hold_viol != 0) begin
            fails++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", hold_viol);
        end
        tests++;
        if (q_data.size() != 20) begin
            fails++; $display("FAIL bp_count: got %0d words expected 20", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            exp_w = {8'h21 + 8'(i), (i >= 16), (i == 19)};
            got_w = {q_data[i], q_kind[i], q_last[i]};
            tests++;
            if (got_w !== exp_w) begin
                fails++; $display("FAIL bp_word%0d: got %h expected %h", i, got_w, exp_w);
            end
        end
    endtask

    task automatic test_full_plus_pop();
        run_job(8'h41, 1'b1, 10, -1, 1'b0, 0);
        tests++;
        if (rdy_log[10] !== 1'b0) begin
            fails++; $display("FAIL fpp_blocked: got snk_rdy %b expected 0", rdy_log[10]);
        end
        tests++;
        if (rdy_log[11] !== 1'b1) begin
            fails++; $display("FAIL fpp_reopen: got snk_rdy %b expected 1", rdy_log[11]);
        end
        tests++;
        if (q_data.size() != 20 || q_data[4] !== 8'h45) begin
            fails++; $display("FAIL fpp_order: got %0d words, word4 %h expected 20, 45",
                              q_data.size(), (q_data.size() > 4) ? q_data[4] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_w, got_w;
        run_job(8'h61, 1'b1, 0, 3, 1'b1, 0);
        tests++;
        if (busy_log[3] !== 1'b1 || q_data.size() != 20 || done_cnt != 1) begin
            fails++; $display("FAIL b2b_ignored_start: got busy %b words %0d done %0d expected 1, 20, 1",
                              busy_log[3], q_data.size(), done_cnt);
        end
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            tests++;
            if (q_data[i] !== 8'h61 + 8'(i)) begin
                fails++; $display("FAIL b2b_job1_word%0d: got %h expected %h", i, q_data[i], 8'h61 + 8'(i));
            end
        end
        run_job(8'h81, 1'b0, 0, -1, 1'b0, 0);
        tests++;
        if (q_data.size() != 20 || first_out != 1 || done_cnt != 1) begin
            fails++; $display("FAIL b2b_job2: got words %0d first %0d done %0d expected 20, 1, 1",
                              q_data.size(), first_out, done_cnt);
        end
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            exp_w = {8'h81 + 8'(i), (i >= 16), (i == 19)};
            got_w = {q_data[i], q_kind[i], q_last[i]};
            tests++;
            if (got_w !== exp_w) begin
                fails++; $display("FAIL b2b_job2_word%0d: got %h expected %h", i, got_w, exp_w);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        logic [9:0] exp_w, got_w;
        run_job(8'hA1, 1'b1, 0, -1, 1'b0, 7);
        tests++;
        if (n_in != 7 || done_cnt != 0) begin
            fails++; $display("FAIL mid_setup: got %0d accepted, done %0d expected 7, 0", n_in, done_cnt);
        end
        rst_n = 1'b0; snk_vld = 1'b1; src_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk); #1;
            tests++;
            if ({snk_rdy, src_vld, src_data, src_kind, src_last, busy, done} !== 14'd0) begin
                fails++; $display("FAIL mid_reset cycle %0d: got %b expected all zero", k,
                                  {snk_rdy, src_vld, src_data, src_kind, src_last, busy, done});
            end
        end
        rst_n = 1'b1; src_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk); #1;
            tests++;
            if ({src_vld, busy, done} !== 3'b000) begin
                fails++; $display("FAIL mid_after cycle %0d: got vld/busy/done=%b expected 000", k,
                                  {src_vld, busy, done});
            end
        end
        snk_vld = 1'b0;
        @(negedge clk);
        run_job(8'hC1, 1'b1, 0, -1, 1'b0, 0);
        tests++;
        if (q_data.size() != 20 || done_cnt != 1) begin
            fails++; $display("FAIL mid_new_job: got words %0d done %0d expected 20, 1", q_data.size(), done_cnt);
        end
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            exp_w = {8'hC1 + 8'(i), (i >= 16), (i == 19)};
            got_w = {q_data[i], q_kind[i], q_last[i]};
            tests++;
            if (got_w !== exp_w) begin
                fails++; $display("FAIL mid_new_word%0d: got %h expected %h", i, got_w, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_back_pressure();
        test_full_plus_pop();
        test_back_to_back();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream feeder for the matrix core: accepts a raw operand word stream from the memory/DMA side and emits one framed job to the matrix core's sink port.
- Each job is ROWS*COLS weight words followed by COLS vector words. Every word carries a kind tag and a last flag.
- Internal FIFO decouples upstream bursts from matrix-core back-pressure.
- Simple FSM gates acceptance to exactly one job per start pulse.

Parameters:
- DATA_WIDTH, 8, operand word width (matches constants package).
- ROWS, 4, matrix rows per job.
- COLS, 4, matrix columns and vector length per job.
- FIFO_DEPTH, 4, internal buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  job start pulse; honoured only in IDLE.
- snk_vld  in  1  upstream word valid.
- snk_rdy  out  1  loader can accept a word.
- snk_data  in  DATA_WIDTH  upstream operand word.
- src_vld  out  1  word valid toward matrix core.
- src_rdy  in  1  matrix core accepts word.
- src_data  out  DATA_WIDTH  operand word toward matrix core.
- src_kind  out  1  0 = weight word, 1 = vector word.
- src_last  out  1  final word of job (last vector element).
- busy  out  1  high in FILL and DRAIN.
- done  out  1  one-cycle pulse when the last word is handed off.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset: state=IDLE; FIFO empty; word counter=0; snk_rdy=0, src_vld=0, src_data=0, src_kind=0, src_last=0, busy=0, done=0.
- A reset mid-job discards all buffered words and counts. No done pulse is produced.
- Handshakes: transfer occurs on a clock edge where vld && rdy. Once src_vld is high, src_data/src_kind/src_last are held stable until src_rdy is seen.
- snk_rdy = (state==FILL) && !fifo_full. It is combinational from registered state and count; there is no dependence on snk_vld.
- Tagging: let TOTAL = ROWS*COLS + COLS and in_cnt = words accepted this job (0..TOTAL-1).
  - Word accepted at in_cnt < ROWS*COLS gets kind=0; otherwise kind=1.
  - last=1 only at in_cnt == TOTAL-1.
  - Tags are stored in the FIFO alongside the data.
- FSM:
  - IDLE: busy=0. start=1 -> FILL, with in_cnt cleared.
  - FILL: accept words. On acceptance of word TOTAL-1 -> DRAIN.
  - DRAIN: snk_rdy=0. When the FIFO entry with last=1 transfers on src -> IDLE, with done=1 in the following cycle (registered pulse).
- start while not in IDLE is ignored.
- start in the same cycle done is high is honoured (state is already IDLE).
- Latency: a word accepted at edge N can appear on src at edge N+1 at the earliest (registered FIFO, no bypass).
- Sustained throughput is 1 word/clock when src_rdy is held high.
- FIFO full: snk_rdy=0 in that cycle, even if a pop occurs the same cycle (no full-push-through).
- FIFO empty: src_vld=0. Simultaneous push and pop when non-empty and non-full leaves occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- in_cnt width is clog2(TOTAL). No arithmetic overflow is possible, since in_cnt never exceeds TOTAL-1.
- snk_vld high while snk_rdy=0 (IDLE, DRAIN, full) has no effect. Data is not captured.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, snk_vld=1 -> snk_rdy=0, src_vld=0, busy=0, done=0 throughout; no word accepted.
- Full job, no back-pressure: start, stream 0x01..0x14 (20 words, ROWS=COLS=4), src_rdy=1 -> src outputs 0x01..0x14 in order.
  - kind=0 for 0x01..0x10, kind=1 for 0x11..0x14.
  - src_last only on 0x14; done pulses once, one cycle after that transfer.
- Back-pressure: src_rdy=0 for 10 cycles mid-job -> snk_rdy drops after 4 accepted words (FIFO_DEPTH=4); src_data stable while stalled; no loss or duplication after release.
- Full-plus-pop: FIFO full and src_rdy=1 in the same cycle -> that cycle snk_rdy=0; the next cycle snk_rdy=1 with occupancy 3.
- Ignored start and back-to-back jobs: start pulsed during FILL has no effect. A second start in the done cycle begins job 2; job 2 tags restart at kind=0.
- Reset mid-job: rst_n=0 after 7 accepted words -> all outputs return to reset values and there is no done pulse. A new job then runs clean with 20 correctly tagged words.
